// File: rtl/data_mem_port.sv
// Data-memory port for the RV32I pipeline: byte-lane RAM, sub-word load extension,
// LED/cycle-counter MMIO page and a sticky misalignment flag.
module data_mem_port #(
   parameter int          DEPTH_WORDS = 1024,
   parameter logic [19:0] MMIO_BASE   = 20'h00002
) (
   input  logic        clk_i,
   input  logic        rstn_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   input  logic        memwrite_i,
   input  logic        memread_i,
   input  logic [3:0]  sign_mask_i,
   output logic [31:0] rdata_o,
   output logic [7:0]  led_o,
   output logic        misalign_o
);

   localparam int AW = $clog2(DEPTH_WORDS);

   logic [31:0]   mem_r [DEPTH_WORDS];
   logic [31:0]   data_r;
   logic [1:0]    off_r;
   logic [3:0]    mask_r;
   logic          region_r;
   logic          ld_mis_r;
   logic          misalign_r;
   logic [7:0]    led_r;
   logic [31:0]   cycle_r;

   logic [AW-1:0] idx_s;
   logic          is_mmio_s;
   logic          is_word_s;
   logic          mis_s;
   logic          ram_we_s;
   logic [3:0]    be_s;
   logic [31:0]   wlane_s;
   logic [31:0]   mmio_val_s;
   logic [31:0]   ld_val_s;
   logic [7:0]    sel_byte_s;
   logic [15:0]   sel_half_s;
   logic [31:0]   rdata_s;

   function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic zext);
      return zext ? {24'h000000, b} : {{24{b[7]}}, b};
   endfunction

   function automatic logic [31:0] ext_half(input logic [15:0] h, input logic zext);
      return zext ? {16'h0000, h} : {{16{h[15]}}, h};
   endfunction

   // Request decode: region, alignment, lane enables and the value a load would capture
   always_comb begin
      idx_s     = addr_i[AW+1:2];
      is_mmio_s = (addr_i[31:12] == MMIO_BASE);
      is_word_s = (sign_mask_i[2:0] == 3'b111);
      be_s      = 4'b0000;
      wlane_s   = wdata_i;
      mis_s     = 1'b1;
      case (sign_mask_i[2:0])
         3'b001: begin
            mis_s               = 1'b0;
            be_s[addr_i[1:0]]   = 1'b1;
            wlane_s             = {4{wdata_i[7:0]}};
         end
         3'b011: begin
            mis_s   = addr_i[0];
            be_s    = addr_i[1] ? 4'b1100 : 4'b0011;
            wlane_s = {2{wdata_i[15:0]}};
         end
         3'b111: begin
            mis_s = (addr_i[1:0] != 2'b00);
            be_s  = 4'b1111;
         end
         default: begin
            mis_s = 1'b1;
            be_s  = 4'b0000;
         end
      endcase
      ram_we_s = memwrite_i && !mis_s && !is_mmio_s;
      case (addr_i[11:0])
         12'h000: mmio_val_s = {24'h000000, led_r};
         12'h004: mmio_val_s = cycle_r;
         default: mmio_val_s = 32'h00000000;
      endcase
      // Sub-word MMIO reads are dropped here; misaligned loads capture zero
      ld_val_s = mis_s     ? 32'h00000000 :
                 is_mmio_s ? (is_word_s ? mmio_val_s : 32'h00000000) :
                             mem_r[idx_s];
   end

   // RAM byte-lane write; contents are intentionally not reset
   always_ff @(posedge clk_i) begin
      for (int i = 0; i < 4; i++) begin
         if (ram_we_s && be_s[i]) begin
            mem_r[idx_s][8*i +: 8] <= wlane_s[8*i +: 8];
         end
      end
   end

   // Load capture, LED register, cycle counter and sticky misalign flag
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         data_r     <= 32'h00000000;
         off_r      <= 2'b00;
         mask_r     <= 4'b0000;
         region_r   <= 1'b0;
         ld_mis_r   <= 1'b0;
         misalign_r <= 1'b0;
         led_r      <= 8'h00;
         cycle_r    <= 32'h00000000;
      end else begin
         cycle_r <= cycle_r + 32'd1;
         if (memread_i) begin
            data_r   <= ld_val_s;
            off_r    <= addr_i[1:0];
            mask_r   <= sign_mask_i;
            region_r <= is_mmio_s;
            ld_mis_r <= mis_s;
         end
         if ((memread_i || memwrite_i) && mis_s) begin
            misalign_r <= 1'b1;
         end
         if (memwrite_i && is_mmio_s && is_word_s && !mis_s && (addr_i[11:0] == 12'h000)) begin
            led_r <= wdata_i[7:0];
         end
      end
   end

   // Load data extraction and extension from the captured word
   always_comb begin
      rdata_s    = 32'h00000000;
      sel_byte_s = data_r[{off_r, 3'b000} +: 8];
      sel_half_s = off_r[1] ? data_r[31:16] : data_r[15:0];
      if (ld_mis_r || (region_r && (mask_r[2:0] != 3'b111))) begin
         rdata_s = 32'h00000000;
      end else begin
         case (mask_r[2:0])
            3'b001:  rdata_s = ext_byte(sel_byte_s, mask_r[3]);
            3'b011:  rdata_s = ext_half(sel_half_s, mask_r[3]);
            3'b111:  rdata_s = data_r;
            default: rdata_s = 32'h00000000;
         endcase
      end
   end

   assign rdata_o    = rdata_s;
   assign led_o      = led_r;
   assign misalign_o = misalign_r;

endmodule

// File: tb/tb_data_mem_port.sv
// Scoreboard bench for data_mem_port: expected load data is queued when a step is
// driven and popped once the DUT has produced rdata_o.
module tb_data_mem_port;

   logic        clk_i = 1'b0;
   logic        rstn_i;
   logic [31:0] addr_i;
   logic [31:0] wdata_i;
   logic        memwrite_i;
   logic        memread_i;
   logic [3:0]  sign_mask_i;
   logic [31:0] rdata_o;
   logic [7:0]  led_o;
   logic        misalign_o;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_q [$];
   logic [31:0] cnt_m;

   typedef struct packed {
      logic        chk;
      logic        we;
      logic        re;
      logic [31:0] a;
      logic [31:0] wd;
      logic [3:0]  m;
      logic [31:0] e;
   } step_t;

   data_mem_port #(.DEPTH_WORDS(1024), .MMIO_BASE(20'h00002)) dut (
      .clk_i       (clk_i),
      .rstn_i      (rstn_i),
      .addr_i      (addr_i),
      .wdata_i     (wdata_i),
      .memwrite_i  (memwrite_i),
      .memread_i   (memread_i),
      .sign_mask_i (sign_mask_i),
      .rdata_o     (rdata_o),
      .led_o       (led_o),
      .misalign_o  (misalign_o)
   );

   always #5 clk_i = ~clk_i;

   // reference cycle counter
   always @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) cnt_m <= 32'h0;
      else         cnt_m <= cnt_m + 32'd1;
   end

   task automatic cyc(input logic we, input logic re, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] m);
      memwrite_i  = we;
      memread_i   = re;
      addr_i      = a;
      wdata_i     = wd;
      sign_mask_i = m;
      @(posedge clk_i);
      #1;
      memwrite_i = 1'b0;
      memread_i  = 1'b0;
   endtask

   task automatic test_reset();
      rstn_i = 1'b1;
      memwrite_i = 1'b0; memread_i = 1'b0;
      addr_i = 32'h0; wdata_i = 32'h0; sign_mask_i = 4'h0;
      #2 rstn_i = 1'b0;
      #2;
      checks++; if (rdata_o !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want %h", rdata_o, 32'h0); end
      checks++; if (led_o !== 8'h0) begin errors++; $display("FAIL reset_led got %h want %h", led_o, 8'h0); end
      checks++; if (misalign_o !== 1'b0) begin errors++; $display("FAIL reset_misalign got %b want 0", misalign_o); end
      #18 rstn_i = 1'b1;
      @(posedge clk_i); #1;
   endtask

   task automatic test_word_byte_half();
      step_t tbl [16];
      logic [31:0] e;
      tbl = '{
         '{1'b0, 1'b1, 1'b0, 32'h40, 32'hDEADBEEF, 4'b0111, 32'h0},
         '{1'b1, 1'b0, 1'b1, 32'h40, 32'h0,        4'b0111, 32'hDEADBEEF},
         '{1'b1, 1'b0, 1'b0, 32'h0,  32'h0,        4'b0000, 32'hDEADBEEF},
         '{1'b1, 1'b0, 1'b0, 32'h0,  32'h0,        4'b0000, 32'hDEADBEEF},
         '{1'b0, 1'b1, 1'b0, 32'h41, 32'h00000080, 4'b0001, 32'h0},
         '{1'b1, 1'b0, 1'b1, 32'h41, 32'h0,        4'b0001, 32'hFFFFFF80},
         '{1'b1, 1'b0, 1'b1, 32'h41, 32'h0,        4'b1001, 32'h00000080},
         '{1'b1, 1'b0, 1'b1, 32'h40, 32'h0,        4'b0111, 32'hDEAD80EF},
         '{1'b0, 1'b1, 1'b0, 32'h42, 32'h00008001, 4'b0011, 32'h0},
         '{1'b1, 1'b0, 1'b1, 32'h42, 32'h0,        4'b0011, 32'hFFFF8001},
         '{1'b1, 1'b0, 1'b1, 32'h42, 32'h0,        4'b1011, 32'h00008001},
         '{1'b1, 1'b0, 1'b1, 32'h43, 32'h0,        4'b0011, 32'h00000000},
         '{1'b0, 1'b1, 1'b0, 32'h43, 32'h0000FFFF, 4'b0011, 32'h0},
         '{1'b0, 1'b1, 1'b0, 32'h40, 32'h11111111, 4'b0010, 32'h0},
         '{1'b1, 1'b0, 1'b1, 32'h40, 32'h0,        4'b0111, 32'h800180EF},
         '{1'b1, 1'b0, 1'b1, 32'h43, 32'h0,        4'b1001, 32'h00000080}
      };
      foreach (tbl[i]) begin
         if (tbl[i].chk) exp_q.push_back(tbl[i].e);
         cyc(tbl[i].we, tbl[i].re, tbl[i].a, tbl[i].wd, tbl[i].m);
         if (tbl[i].chk) begin
            e = exp_q.pop_front();
            checks++;
            if (rdata_o !== e) begin errors++; $display("FAIL ram_step[%0d] rdata got %h want %h", i, rdata_o, e); end
         end
      end
      checks++; if (misalign_o !== 1'b1) begin errors++; $display("FAIL misalign_sticky got %b want 1", misalign_o); end
   endtask

   task automatic test_mmio();
      step_t tbl [6];
      logic [31:0] e;
      logic [31:0] c0;
      logic [31:0] c1;
      tbl = '{
         '{1'b0, 1'b1, 1'b0, 32'h2000, 32'h0000005A, 4'b0111, 32'h0},
         '{1'b1, 1'b0, 1'b1, 32'h2000, 32'h0,        4'b0111, 32'h0000005A},
         '{1'b1, 1'b0, 1'b1, 32'h2000, 32'h0,        4'b1001, 32'h00000000},
         '{1'b0, 1'b1, 1'b0, 32'h2000, 32'h00000011, 4'b0001, 32'h0},
         '{1'b1, 1'b0, 1'b1, 32'h2008, 32'h0,        4'b0111, 32'h00000000},
         '{1'b1, 1'b0, 1'b1, 32'h2000, 32'h0,        4'b0111, 32'h0000005A}
      };
      foreach (tbl[i]) begin
         if (tbl[i].chk) exp_q.push_back(tbl[i].e);
         cyc(tbl[i].we, tbl[i].re, tbl[i].a, tbl[i].wd, tbl[i].m);
         if (tbl[i].chk) begin
            e = exp_q.pop_front();
            checks++;
            if (rdata_o !== e) begin errors++; $display("FAIL mmio_step[%0d] rdata got %h want %h", i, rdata_o, e); end
         end
         if (i == 0) begin
            checks++;
            if (led_o !== 8'h5A) begin errors++; $display("FAIL led_write got %h want %h", led_o, 8'h5A); end
         end
      end
      checks++; if (led_o !== 8'h5A) begin errors++; $display("FAIL led_subword_ignored got %h want %h", led_o, 8'h5A); end

      exp_q.push_back(cnt_m);
      cyc(1'b0, 1'b1, 32'h2004, 32'h0, 4'b0111);
      c0 = rdata_o;
      e = exp_q.pop_front();
      checks++; if (c0 !== e) begin errors++; $display("FAIL counter_a got %h want %h", c0, e); end
      cyc(1'b1, 1'b0, 32'h2004, 32'h00000000, 4'b0111);
      cyc(1'b0, 1'b0, 32'h0, 32'h0, 4'b0000);
      exp_q.push_back(cnt_m);
      cyc(1'b0, 1'b1, 32'h2004, 32'h0, 4'b0111);
      c1 = rdata_o;
      e = exp_q.pop_front();
      checks++; if (c1 !== e) begin errors++; $display("FAIL counter_b got %h want %h", c1, e); end
      checks++; if ((c1 - c0) !== 32'd3) begin errors++; $display("FAIL counter_delta got %0d want 3", c1 - c0); end
   endtask

   task automatic test_back_to_back();
      step_t tbl [5];
      logic [31:0] e;
      tbl = '{
         '{1'b0, 1'b1, 1'b0, 32'h1000, 32'h12345678, 4'b0111, 32'h0},
         '{1'b1, 1'b0, 1'b1, 32'h0000, 32'h0,        4'b0111, 32'h12345678},
         '{1'b1, 1'b1, 1'b1, 32'h0040, 32'hCAFEF00D, 4'b0111, 32'h800180EF},
         '{1'b1, 1'b0, 1'b1, 32'h0040, 32'h0,        4'b0111, 32'hCAFEF00D},
         '{1'b1, 1'b0, 1'b1, 32'h0042, 32'h0,        4'b0011, 32'hFFFFCAFE}
      };
      foreach (tbl[i]) begin
         if (tbl[i].chk) exp_q.push_back(tbl[i].e);
         cyc(tbl[i].we, tbl[i].re, tbl[i].a, tbl[i].wd, tbl[i].m);
         if (tbl[i].chk) begin
            e = exp_q.pop_front();
            checks++;
            if (rdata_o !== e) begin errors++; $display("FAIL b2b_step[%0d] rdata got %h want %h", i, rdata_o, e); end
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] e;
      #3 rstn_i = 1'b0;
      #1;
      checks++; if (led_o !== 8'h00) begin errors++; $display("FAIL midreset_led got %h want %h", led_o, 8'h00); end
      checks++; if (rdata_o !== 32'h0) begin errors++; $display("FAIL midreset_rdata got %h want %h", rdata_o, 32'h0); end
      checks++; if (misalign_o !== 1'b0) begin errors++; $display("FAIL midreset_misalign got %b want 0", misalign_o); end
      #2 rstn_i = 1'b1;
      @(posedge clk_i); #1;
      exp_q.push_back(32'hCAFEF00D);
      cyc(1'b0, 1'b1, 32'h40, 32'h0, 4'b0111);
      e = exp_q.pop_front();
      checks++; if (rdata_o !== e) begin errors++; $display("FAIL ram_survives_reset got %h want %h", rdata_o, e); end
      exp_q.push_back(cnt_m);
      cyc(1'b0, 1'b1, 32'h2004, 32'h0, 4'b0111);
      e = exp_q.pop_front();
      checks++; if (rdata_o !== e) begin errors++; $display("FAIL counter_after_reset got %h want %h", rdata_o, e); end
   endtask

   initial begin
      test_reset();
      test_word_byte_half();
      test_mmio();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
